// File: rtl/xpb_lut_sched.sv
// xpb_lut_sched: time-multiplexes one shared xpb lookup-table bank across the
// upper-bit segments of a modular-squaring reduction and accumulates the
// returned multiples into a guarded, never-truncated sum.
// Optional build macro XPB_ZERO_SKIP_EN: skip lookups for zero-valued segments.
module xpb_lut_sched #(
    parameter int NUM_SEGS   = 8,
    parameter int SEG_BITS   = 5,
    parameter int WORD_BITS  = 1024,
    parameter int GUARD_BITS = 3,
    parameter int LUT_LAT    = 1,
    localparam int SEL_W     = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
    localparam int ACC_BITS  = WORD_BITS + GUARD_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_SEGS*SEG_BITS-1:0] in_segs,
    output logic                         lut_req,
    output logic [SEL_W-1:0]             lut_sel,
    output logic [SEG_BITS-1:0]          lut_addr,
    input  logic [WORD_BITS-1:0]         lut_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_BITS-1:0]          out_sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [NUM_SEGS*SEG_BITS-1:0]  r_segs;
    logic [LUT_LAT-1:0]            r_pipe;
    logic [ACC_BITS-1:0]           r_acc;
    logic [LUT_LAT-1:0]            w_pipe_rest;
    logic                          w_tail;
    logic                          w_accept;
    logic                          w_issue;
    logic                          w_last;
    logic [SEL_W-1:0]              w_sel;
    logic [SEG_BITS-1:0]           w_addr;

    // Pipe contents after the next shift, ignoring any new request; empty means
    // the final return lands this cycle.
    assign w_pipe_rest = r_pipe << 1;
    assign w_tail      = r_pipe[LUT_LAT-1];
    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_issue     = (r_state == S_ISSUE);
    assign out_sum     = r_acc;

`ifdef XPB_ZERO_SKIP_EN
    logic [NUM_SEGS-1:0] r_mask;
    logic [NUM_SEGS-1:0] w_in_nz;
    logic [NUM_SEGS-1:0] w_mask_clr;
    logic                w_found;

    // Nonzero-segment mask of the offered vector
    always_comb begin
        w_in_nz = '0;
        for (int unsigned i = 0; i < NUM_SEGS; i++)
            w_in_nz[i] = |in_segs[i*SEG_BITS +: SEG_BITS];
    end

    // Priority encoder: lowest remaining nonzero segment is issued next
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SEGS; i++) begin
            if (r_mask[i] && !w_found) begin
                w_sel   = SEL_W'(i);
                w_found = 1'b1;
            end
        end
        w_mask_clr = r_mask & ~(NUM_SEGS'(1) << w_sel);
        w_last     = (w_mask_clr == '0);
    end

    // Remaining-segment mask: loaded on accept, one bit retired per issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_mask <= '0;
        else if (w_accept) r_mask <= w_in_nz;
        else if (w_issue)  r_mask <= w_mask_clr;
    end
`else
    logic [SEL_W-1:0] r_cnt;

    assign w_sel  = r_cnt;
    assign w_last = (r_cnt == SEL_W'(NUM_SEGS - 1));

    // Segment counter: restarts on accept, advances once per issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_cnt <= '0;
        else if (w_accept) r_cnt <= '0;
        else if (w_issue)  r_cnt <= r_cnt + 1'b1;
    end
`endif

    // Address mux: pick the latched segment selected for this issue
    always_comb begin
        w_addr = '0;
        for (int unsigned i = 0; i < NUM_SEGS; i++)
            if (SEL_W'(i) == w_sel) w_addr = r_segs[i*SEG_BITS +: SEG_BITS];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef XPB_ZERO_SKIP_EN
                if (in_valid) w_next = (w_in_nz == '0) ? S_DONE : S_ISSUE;
`else
                if (in_valid) w_next = S_ISSUE;
`endif
            end
            S_ISSUE: if (w_last)             w_next = S_DRAIN;
            S_DRAIN: if (w_pipe_rest == '0)  w_next = S_DONE;
            S_DONE:  if (out_ready)          w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        lut_req   = w_issue;
        lut_sel   = w_issue ? w_sel : '0;
        lut_addr  = w_issue ? w_addr : '0;
    end

    // Datapath: latch segments, track in-flight lookups, accumulate returns
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_segs <= '0;
            r_pipe <= '0;
            r_acc  <= '0;
        end else begin
            r_pipe <= w_pipe_rest | LUT_LAT'(lut_req);
            if (w_accept) begin
                r_segs <= in_segs;
                r_acc  <= '0;
            end else if (w_tail) begin
                r_acc  <= r_acc + ACC_BITS'(lut_data);
            end
        end
    end

endmodule
